// File: rtl/mike_cache_nway.sv
// N-way set-associative write-back/write-allocate cache with tree-PLRU replacement,
// invalid-way-first victim choice and saturating hit/miss counters.
module mike_cache_nway #(
   parameter int unsigned s_offset = 5,
   parameter int unsigned s_index  = 3,
   parameter int unsigned s_ways   = 2
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [31:0]                  mem_address,
   input  logic                         mem_read,
   input  logic                         mem_write,
   input  logic [(1<<s_offset)-1:0]     mem_byte_enable,
   input  logic [(8<<s_offset)-1:0]     mem_wdata,
   output logic [(8<<s_offset)-1:0]     mem_rdata,
   output logic                         mem_resp,
   output logic [31:0]                  pmem_address,
   output logic                         pmem_read,
   output logic                         pmem_write,
   input  logic [(8<<s_offset)-1:0]     pmem_rdata,
   output logic [(8<<s_offset)-1:0]     pmem_wdata,
   input  logic                         pmem_resp,
   output logic [31:0]                  hit_count,
   output logic [31:0]                  miss_count
);

   localparam int unsigned s_tag    = 32 - s_offset - s_index;
   localparam int unsigned s_mask   = 1 << s_offset;
   localparam int unsigned s_line   = 8 * s_mask;
   localparam int unsigned num_sets = 1 << s_index;
   localparam int unsigned num_ways = 1 << s_ways;

   typedef enum logic [1:0] {
      CHECK     = 2'd0,
      WRITEBACK = 2'd1,
      FILL      = 2'd2
   } state_e;

   typedef logic [num_ways-2:0] tree_t;
   typedef logic [s_ways-1:0]   way_t;

   // Walk the PLRU tree: a 0 bit points to the lower half, 1 to the upper half.
   function automatic way_t plru_victim(input tree_t t);
      int unsigned node;
      node = 0;
      for (int unsigned l = 0; l < s_ways; l++) begin
         node = 2 * node + 1 + ((((t >> node) & tree_t'(1)) != '0) ? 1 : 0);
      end
      return s_ways'(node - (num_ways - 1));
   endfunction

   // Point every node on the accessed way's path away from that way.
   function automatic tree_t plru_touch(input tree_t t, input way_t w);
      int unsigned node;
      tree_t       r;
      logic        dir;
      r    = t;
      node = 0;
      for (int unsigned l = 0; l < s_ways; l++) begin
         dir  = ((w >> (s_ways - 1 - l)) & way_t'(1)) != '0;
         r    = (r & ~(tree_t'(1) << node)) | ((dir ? tree_t'(0) : tree_t'(1)) << node);
         node = 2 * node + 1 + (dir ? 1 : 0);
      end
      return r;
   endfunction

   // Storage: data/tag are not reset, state bits are.
   logic [s_line-1:0]   data_q  [num_sets][num_ways];
   logic [s_tag-1:0]    tag_q   [num_sets][num_ways];
   logic [num_ways-1:0] valid_q [num_sets];
   logic [num_ways-1:0] dirty_q [num_sets];
   tree_t               plru_q  [num_sets];

   state_e              state_q, state_d;
   way_t                victim_q, victim_d;
   logic [s_tag-1:0]    req_tag_q, req_tag_d;
   logic [s_index-1:0]  idx_q, idx_d;
   logic [31:0]         hit_count_q, miss_count_q;

   logic [s_tag-1:0]    tag_c;
   logic [s_index-1:0]  idx_c;
   logic                req_c;
   logic                hit_c;
   way_t                hit_way_c;
   logic                has_inv_c;
   way_t                inv_way_c;
   way_t                victim_c;
   logic [s_line-1:0]   hit_line_c;
   logic [s_line-1:0]   merged_c;
   logic                hit_inc_c;
   logic                miss_inc_c;
   logic                wr_hit_c;
   logic                fill_we_c;
   logic                unused_c;

   assign tag_c    = mem_address[31 -: s_tag];
   assign idx_c    = mem_address[s_offset +: s_index];
   assign req_c    = mem_read | mem_write;
   assign unused_c = ^mem_address[s_offset-1:0];

   // Tag lookup and lowest-index invalid way for the requested set.
   always_comb begin
      hit_c     = 1'b0;
      hit_way_c = '0;
      has_inv_c = 1'b0;
      inv_way_c = '0;
      for (int unsigned w = 0; w < num_ways; w++) begin
         if (valid_q[idx_c][w] && (tag_q[idx_c][w] == tag_c)) begin
            hit_c     = 1'b1;
            hit_way_c = s_ways'(w);
         end
         if (!valid_q[idx_c][w] && !has_inv_c) begin
            has_inv_c = 1'b1;
            inv_way_c = s_ways'(w);
         end
      end
   end

   assign victim_c   = has_inv_c ? inv_way_c : plru_victim(plru_q[idx_c]);
   assign hit_line_c = data_q[idx_c][hit_way_c];

   always_comb begin
      merged_c = hit_line_c;
      for (int unsigned b = 0; b < s_mask; b++) begin
         if (mem_byte_enable[b]) begin
            merged_c[8*b +: 8] = mem_wdata[8*b +: 8];
         end
      end
   end

   // Controller next-state and outputs.
   always_comb begin
      state_d      = state_q;
      victim_d     = victim_q;
      req_tag_d    = req_tag_q;
      idx_d        = idx_q;
      mem_resp     = 1'b0;
      mem_rdata    = hit_line_c;
      pmem_read    = 1'b0;
      pmem_write   = 1'b0;
      pmem_address = '0;
      pmem_wdata   = data_q[idx_q][victim_q];
      hit_inc_c    = 1'b0;
      miss_inc_c   = 1'b0;
      wr_hit_c     = 1'b0;
      fill_we_c    = 1'b0;
      unique case (state_q)
         CHECK: begin
            if (req_c) begin
               if (hit_c) begin
                  mem_resp  = 1'b1;
                  hit_inc_c = 1'b1;
                  wr_hit_c  = mem_write;
               end else begin
                  miss_inc_c = 1'b1;
                  victim_d   = victim_c;
                  req_tag_d  = tag_c;
                  idx_d      = idx_c;
                  if (valid_q[idx_c][victim_c] && dirty_q[idx_c][victim_c]) begin
                     state_d = WRITEBACK;
                  end else begin
                     state_d = FILL;
                  end
               end
            end
         end
         WRITEBACK: begin
            pmem_write   = 1'b1;
            pmem_address = {tag_q[idx_q][victim_q], idx_q, {s_offset{1'b0}}};
            if (pmem_resp) begin
               state_d = FILL;
            end
         end
         FILL: begin
            pmem_read    = 1'b1;
            pmem_address = {req_tag_q, idx_q, {s_offset{1'b0}}};
            if (pmem_resp) begin
               fill_we_c = 1'b1;
               state_d   = CHECK;
            end
         end
         default: begin
            state_d = CHECK;
         end
      endcase
   end

   // Controller and metadata state.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= CHECK;
         victim_q     <= '0;
         req_tag_q    <= '0;
         idx_q        <= '0;
         hit_count_q  <= '0;
         miss_count_q <= '0;
         for (int unsigned s = 0; s < num_sets; s++) begin
            valid_q[s] <= '0;
            dirty_q[s] <= '0;
            plru_q[s]  <= '0;
         end
      end else begin
         state_q   <= state_d;
         victim_q  <= victim_d;
         req_tag_q <= req_tag_d;
         idx_q     <= idx_d;
         if (hit_inc_c && (hit_count_q != 32'hFFFF_FFFF)) begin
            hit_count_q <= hit_count_q + 32'd1;
         end
         if (miss_inc_c && (miss_count_q != 32'hFFFF_FFFF)) begin
            miss_count_q <= miss_count_q + 32'd1;
         end
         if (fill_we_c) begin
            valid_q[idx_q][victim_q] <= 1'b1;
            dirty_q[idx_q][victim_q] <= 1'b0;
         end
         if (wr_hit_c) begin
            dirty_q[idx_c][hit_way_c] <= 1'b1;
         end
         if (hit_inc_c) begin
            plru_q[idx_c] <= plru_touch(plru_q[idx_c], hit_way_c);
         end
      end
   end

   // Line data and tags: fill from memory or byte-merge on a write hit.
   always_ff @(posedge clk) begin
      if (fill_we_c) begin
         data_q[idx_q][victim_q] <= pmem_rdata;
         tag_q[idx_q][victim_q]  <= req_tag_q;
      end else if (wr_hit_c) begin
         data_q[idx_c][hit_way_c] <= merged_c;
      end
   end

   assign hit_count  = hit_count_q;
   assign miss_count = miss_count_q;

endmodule

// File: doc/mike_cache_nway.md
Name: mike_cache_nway

Overview:
Parametrised N-way set-associative write-back, write-allocate cache with its own controller FSM. It replaces the fixed 2-way datapath-plus-separate-control pair. It sits between the pipeline's memory port (256-bit line interface, byte-enable writes) and physical memory or the arbiter. New in this generation:
- configurable way count with tree pseudo-LRU replacement
- invalid-way-first victim selection
- built-in hit/miss performance counters

Parameters:
s_offset, 5, byte-offset bits; line = 2**s_offset bytes
s_index, 3, set-index bits; num_sets = 2**s_index
s_ways, 2, log2 of associativity; num_ways = 2**s_ways (legal 1..3)
s_tag, 32-s_offset-s_index, tag width
s_mask, 2**s_offset, byte-enable width
s_line, 8*s_mask, line width in bits

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  asynchronous active-low reset
mem_address  in  32  CPU request address
mem_read  in  1  CPU read request; held until mem_resp
mem_write  in  1  CPU write request; held until mem_resp
mem_byte_enable  in  s_mask  per-byte write enable for mem_write
mem_wdata  in  s_line  CPU write line
mem_rdata  out  s_line  line of hit way
mem_resp  out  1  request complete
pmem_address  out  32  line-aligned physical address
pmem_read  out  1  line fill request
pmem_write  out  1  line write-back request
pmem_rdata  in  s_line  fill data, valid with pmem_resp
pmem_wdata  out  s_line  victim line
pmem_resp  in  1  physical memory done (one cycle)
hit_count  out  32  saturating hit counter
miss_count  out  32  saturating miss counter

Behaviour:
- Address split: tag=[31:s_offset+s_index], index=[s_offset+s_index-1:s_offset].
- Per way: data, tag, valid and dirty arrays. Per set: PLRU tree of num_ways-1 bits. All arrays use combinational read and write on the clock edge.
- FSM states: CHECK, WRITEBACK, FILL. Reset state is CHECK.
- CHECK:
  - Request present (mem_read|mem_write) and a way hits (tag match & valid): mem_resp=1 in the same cycle, mem_rdata = hit way line.
  - On write hit: bytes with mem_byte_enable=1 take mem_wdata; dirty set.
  - Every hit updates PLRU and increments hit_count.
  - If both mem_read and mem_write are high, the request is treated as a write.
- Miss in CHECK:
  - Victim = lowest-index invalid way; otherwise the PLRU victim.
  - miss_count increments once per miss, in the CHECK cycle that detects it.
  - Next state is WRITEBACK if the victim is valid&dirty, else FILL.
- WRITEBACK:
  - pmem_write=1, pmem_address={victim tag, index, 0}, pmem_wdata = victim line.
  - Held until pmem_resp, then go to FILL.
- FILL:
  - pmem_read=1, pmem_address={req tag, index, 0}.
  - On pmem_resp: victim line=pmem_rdata, tag written, valid=1, dirty=0; return to CHECK. CHECK then hits and completes the request; that hit also counts in hit_count.
- Victim way is latched on entry to WRITEBACK/FILL and held stable.
- pmem_read and pmem_write are never asserted together. Both are 0 in CHECK.
- PLRU tree:
  - Node k has children 2k+1 and 2k+2; leaves map to ways in order.
  - Victim walk: bit 0 goes to the lower half, 1 to the upper half.
  - On access to way w, each node on w's path is set to point away from w.
- Outputs when idle: mem_resp=0. mem_rdata is don't-care unless mem_resp=1.
- Counters saturate at 32'hFFFF_FFFF.
- Reset (rst=0, asynchronous, any state):
  - FSM goes to CHECK; all valid, dirty, PLRU bits, hit_count and miss_count clear.
  - pmem_read, pmem_write and mem_resp drop immediately.
  - Data and tag contents are not reset.
- Request withdrawn mid-miss (protocol violation): the in-flight pmem transaction still completes, then the FSM returns to CHECK with no mem_resp.
- Write to a line mid-fill from the same request is not possible; the merge occurs only in the subsequent CHECK hit.

Test Plan:
- Reset, read 0x0000_0040 -> pmem_read with pmem_address 0x40, no pmem_write; respond 256'hA5..A5 -> mem_resp, mem_rdata=A5..A5. Re-read -> mem_resp same cycle, no pmem traffic; hit_count=2, miss_count=1.
- s_ways=2: read 0x000,0x100,0x200,0x300 (set 0, ways 0-3 filled), read 0x000, then read 0x400 -> fill replaces way 2. Read 0x200 -> misses; 0x000 and 0x300 still hit.
- Write 0x040 with byte_enable 32'h0000_000F, wdata 0x...DEADBEEF, then force eviction of set 2 -> pmem_write at 0x40 first, line = A5 pattern with low 4 bytes EF BE AD DE. Then pmem_read of the new address.
- Write miss to 0x080 with byte_enable 32'h8000_0000 -> fill then merge; read 0x080 -> byte 31 new, others fill data; dirty eviction later writes back 0x80.
- Assert rst low mid-FILL between clock edges -> pmem_read drops before the next edge; after release, read 0x040 misses, counters are 0 before it.
- Drive hit_count to 32'hFFFF_FFFE via repeated hits -> two more hits leave it at 32'hFFFF_FFFF.
